// File: rtl/riscv_bus_pkg.sv
// Shared definitions for the CPU data-memory request path: FSM state
// encoding, default MMIO window and the "no byte lanes" enable value.
package riscv_bus_pkg;

   // Request demux FSM states
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   // Default MMIO window: the top 64 KiB of the address space
   localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_0000;
   localparam logic [31:0] MMIO_MASK_DEF = 32'hFFFF_0000;

   // A request with no byte lanes enabled is rejected without a bus cycle
   localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/txn_timer.sv
// Saturating transaction timer. expired_o flags the enabled cycle in which
// the count reaches TIMEOUT, so the owner can act on it in that same cycle.
module txn_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up while enabled, stop at TIMEOUT
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // This enabled cycle is the one that brings the count up to TIMEOUT
   assign expired_o = en_i & (cnt_q >= CNT_LAST);

endmodule

// File: rtl/dmem_req_demux2.sv
// Routes one CPU data-memory request to data RAM (port 0) or the MMIO
// window (port 1) and returns that target's response upstream. One
// transaction in flight; a timer turns a silent target into an error.
//
// Handshakes: a request transfers on a cycle where valid && ready are both
// high at the rising edge; valid, once raised, holds with stable fields
// until that edge. Response strobes (rsp_valid, p*_rsp_valid) are single
// cycle with no back-pressure.
module dmem_req_demux2
   import riscv_bus_pkg::*;
#(
   parameter int unsigned        DATA_W    = 32,
   parameter logic [DATA_W-1:0]  MMIO_BASE = DATA_W'(MMIO_BASE_DEF),
   parameter logic [DATA_W-1:0]  MMIO_MASK = DATA_W'(MMIO_MASK_DEF),
   parameter int unsigned        TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              req_we,
   input  logic [3:0]        req_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              p0_req_valid,
   input  logic              p0_req_ready,
   output logic [DATA_W-1:0] p0_addr,
   output logic [DATA_W-1:0] p0_wdata,
   output logic              p0_we,
   output logic [3:0]        p0_be,
   input  logic              p0_rsp_valid,
   input  logic [DATA_W-1:0] p0_rsp_rdata,
   output logic              p1_req_valid,
   input  logic              p1_req_ready,
   output logic [DATA_W-1:0] p1_addr,
   output logic [DATA_W-1:0] p1_wdata,
   output logic              p1_we,
   output logic [3:0]        p1_be,
   input  logic              p1_rsp_valid,
   input  logic [DATA_W-1:0] p1_rsp_rdata,
   output logic [1:0]        dbg_state
);

   logic [1:0]        state_q, state_d;
   logic              sel_q, sel_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              tmr_clr, tmr_en, tmr_expired;

   // Only the selected target's ready/response are ever looked at
   logic              tgt_ready;
   logic              tgt_rsp_valid;
   logic [DATA_W-1:0] tgt_rsp_rdata;

   assign tgt_ready     = sel_q ? p1_req_ready : p0_req_ready;
   assign tgt_rsp_valid = sel_q ? p1_rsp_valid : p0_rsp_valid;
   assign tgt_rsp_rdata = sel_q ? p1_rsp_rdata : p0_rsp_rdata;

   txn_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmr_expired)
   );

   // Transaction FSM: accept, issue to one target, await response or timeout
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               we_d    = req_we;
               be_d    = req_be;
               sel_d   = ((req_addr & MMIO_MASK) == MMIO_BASE);
               if (req_be == BE_NONE) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = ISSUE;
                  tmr_clr = 1'b1;
               end
            end
         end
         ISSUE: begin
            tmr_en = 1'b1;
            if (tmr_expired) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (tgt_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            tmr_en = 1'b1;
            // A response landing on the expiry cycle still completes cleanly
            if (tgt_rsp_valid) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = we_q ? '0 : tgt_rsp_rdata;
            end else if (tmr_expired) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched request/response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid & err_q;
   assign rsp_rdata = rdata_q;
   assign dbg_state = state_q;

   // The unselected port sees all-zero fields
   assign p0_req_valid = (state_q == ISSUE) & ~sel_q;
   assign p0_addr      = sel_q ? '0 : addr_q;
   assign p0_wdata     = sel_q ? '0 : wdata_q;
   assign p0_we        = ~sel_q & we_q;
   assign p0_be        = sel_q ? 4'b0000 : be_q;

   assign p1_req_valid = (state_q == ISSUE) & sel_q;
   assign p1_addr      = sel_q ? addr_q : '0;
   assign p1_wdata     = sel_q ? wdata_q : '0;
   assign p1_we        = sel_q & we_q;
   assign p1_be        = sel_q ? be_q : 4'b0000;

endmodule

// File: tb/tb_dmem_req_demux2.sv
// Bench for dmem_req_demux2: directed cases plus randomized transactions,
// each predicted from a per-transaction latency/result model.
module tb_dmem_req_demux2;

  localparam int T = 8;
  localparam int EW = 41;  // {latency[7:0], err, rdata[31:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        p0_req_valid, p1_req_valid;
  logic        p0_req_ready = 1'b0, p1_req_ready = 1'b0;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_we, p1_we;
  logic [3:0]  p0_be, p1_be;
  logic        p0_rsp_valid = 1'b0, p1_rsp_valid = 1'b0;
  logic [31:0] p0_rsp_rdata = '0, p1_rsp_rdata = '0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  dmem_req_demux2 #(
    .DATA_W    (32),
    .MMIO_BASE (32'hFFFF_0000),
    .MMIO_MASK (32'hFFFF_0000),
    .TIMEOUT   (T)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_we       (req_we),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_we        (p0_we),
    .p0_be        (p0_be),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_we        (p1_we),
    .p1_be        (p1_be),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_rdata (p1_rsp_rdata),
    .dbg_state    (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction from the IDLE cycle. rd = cycles target holds ready low
  // while valid is shown; sd = extra cycles after the minimum response delay.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [3:0] be,
                         input int rd, input int sd, input bit respond);
    bit sel_m, ok, done, pv, po, rdy, rv;
    int lat, vcnt, acc;
    logic [31:0] data;
    logic [EW-1:0] e;
    sel_m = (addr >= 32'hFFFF_0000);
    data  = $urandom();
    ok    = (be != 4'h0) && respond && (rd + 1 + sd <= T - 1);
    if (be == 4'h0) lat = 1;
    else if (ok)    lat = rd + sd + 3;
    else            lat = T + 1;
    exp_q.push_back({8'(lat), !ok, (ok && !we) ? data : 32'h0});
    e = '0;
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_we = we; req_be = be;
    vcnt = 0; acc = -1; done = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom(); req_wdata = $urandom();
      req_we = 1'($urandom_range(0, 1)); req_be = 4'($urandom_range(0, 15));
      pv = sel_m ? p1_req_valid : p0_req_valid;
      po = sel_m ? p0_req_valid : p1_req_valid;
      chk("other_valid", po, 0);
      chk("busy_ready", req_ready, 0);
      if (be == 4'h0) chk("nobe_valid", pv, 0);
      if (pv) begin
        vcnt++;
        chk("tgt_addr",  sel_m ? p1_addr  : p0_addr,  addr);
        chk("tgt_wdata", sel_m ? p1_wdata : p0_wdata, wdata);
        chk("tgt_we",    sel_m ? p1_we    : p0_we,    we);
        chk("tgt_be",    sel_m ? p1_be    : p0_be,    be);
        chk("oth_addr",  sel_m ? p0_addr  : p1_addr,  0);
      end
      rdy = pv ? (vcnt > rd) : 1'($urandom_range(0, 1));
      if (pv && rdy && acc < 0) acc = cyc;
      rv = respond && (acc >= 0) && (cyc == acc + 1 + sd);
      if (sel_m) begin
        p0_req_ready = 1'($urandom_range(0, 1));
        p0_rsp_valid = 1'($urandom_range(0, 1));
        p0_rsp_rdata = $urandom();
        p1_req_ready = rdy; p1_rsp_valid = rv;
        p1_rsp_rdata = rv ? data : $urandom();
      end else begin
        p1_req_ready = 1'($urandom_range(0, 1));
        p1_rsp_valid = 1'($urandom_range(0, 1));
        p1_rsp_rdata = $urandom();
        p0_req_ready = rdy; p0_rsp_valid = rv;
        p0_rsp_rdata = rv ? data : $urandom();
      end
      if (rsp_valid) begin
        e = exp_q.pop_front();
        chk("rsp_latency", 64'(cyc), 64'(e[40:33]));
        chk("rsp_err", rsp_err, e[32]);
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("rsp_missing", 0, 1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end
    p0_rsp_valid = 1'b0; p1_rsp_valid = 1'b0;
    p0_req_ready = 1'b0; p1_req_ready = 1'b0;
    @(posedge clk); #1;
    chk("post_valid", rsp_valid, 0);
    chk("post_err", rsp_err, 0);
    chk("post_rdata_hold", rsp_rdata, e[31:0]);
    chk("post_ready", req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_p0_valid"}, p0_req_valid, 0);
    chk({tag, "_p1_valid"}, p1_req_valid, 0);
    chk({tag, "_p0_fields"}, {p0_addr, p0_wdata}, 0);
    chk({tag, "_p1_fields"}, {p1_addr, p1_wdata}, 0);
    chk({tag, "_be_we"}, {p0_be, p1_be, p0_we, p1_we}, 0);
  endtask

  // Reset pulsed while the transaction waits on data RAM, then a stale reply
  task automatic reset_mid_txn();
    req_valid = 1'b1; req_addr = 32'h0000_0020; req_wdata = '0; req_we = 1'b0; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    p0_req_ready = 1'b1;
    @(posedge clk); #1;
    p0_req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", req_ready, 1);
    p0_rsp_valid = 1'b1; p0_rsp_rdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      p0_rsp_valid = 1'b0;
      chk("stale_rsp_valid", rsp_valid, 0);
      chk("stale_ready", req_ready, 1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  b;
    // reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", req_ready, 1);

    // directed
    run_txn(32'h0000_0010, 32'h0,         1'b0, 4'hF, 0, 0, 1'b1);
    run_txn(32'hFFFF_0004, 32'h0000_00A5, 1'b1, 4'h1, 0, 0, 1'b1);
    run_txn(32'h0000_0100, 32'h0,         1'b0, 4'hF, 5, 0, 1'b1);
    run_txn(32'h0000_0200, 32'h0,         1'b0, 4'hF, 0, 0, 1'b0);
    run_txn(32'h0000_0300, 32'hDEAD_BEEF, 1'b1, 4'h0, 0, 0, 1'b1);
    run_txn(32'hFFFF_0010, 32'h0,         1'b0, 4'hC, 2, 4, 1'b1);
    run_txn(32'hFFFF_0014, 32'h0,         1'b0, 4'h3, 2, 5, 1'b1);
    run_txn(32'h0000_0400, 32'h0,         1'b0, 4'hF, 7, 0, 1'b1);
    run_txn(32'hFFFE_FFFC, 32'h5555_AAAA, 1'b1, 4'hF, 1, 1, 1'b1);

    reset_mid_txn();

    // randomized
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom() & 32'h7FFF_FFFC;
        1:       a = 32'hFFFF_0000 | ($urandom() & 32'h0000_FFFC);
        default: a = 32'hFFFE_0000 | ($urandom() & 32'h0000_FFFC);
      endcase
      b = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_txn(a, $urandom(), 1'($urandom_range(0, 1)), b,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              $urandom_range(0, 7) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_req_demux2.md
Name: dmem_req_demux2

Overview:
- Routes one CPU data-memory request to one of two downstream targets: port 0 is data RAM, port 1 is the MMIO window.
- Carries the selected target's response back upstream.
- This is the request-side counterpart of the writeback 2:1 select: one source fans out to two sinks.
- Sits between the load/store datapath and the memory/peripheral blocks; one transaction outstanding at a time, with a timeout.

Parameters:
- DATA_W, 32, width of address, write data and read data.
- MMIO_BASE, 32'hFFFF_0000, MMIO window base address.
- MMIO_MASK, 32'hFFFF_0000, mask applied to the address before the compare with MMIO_BASE.
- TIMEOUT, 255, cycles allowed from issue to downstream response before an error is returned (minimum 1).

Ports:
- clk input 1 rising-edge clock.
- rst_n input 1 asynchronous active-low reset.
- req_valid input 1 upstream request valid.
- req_ready output 1 block can accept a request.
- req_addr input DATA_W byte address.
- req_wdata input DATA_W store data.
- req_we input 1: 1 = store, 0 = load.
- req_be input 4 byte enables.
- rsp_valid output 1 one-cycle response strobe.
- rsp_rdata output DATA_W load data.
- rsp_err output 1 error flag, qualified by rsp_valid.
- p0_req_valid, p1_req_valid output 1 downstream request valid.
- p0_req_ready, p1_req_ready input 1 downstream accept.
- p0_addr, p1_addr output DATA_W.
- p0_wdata, p1_wdata output DATA_W.
- p0_we, p1_we output 1.
- p0_be, p1_be output 4.
- p0_rsp_valid, p1_rsp_valid input 1 downstream response strobe.
- p0_rsp_rdata, p1_rsp_rdata input DATA_W.

Behaviour:
- One clock (clk); reset rst_n is asynchronous, active-low.
- While rst_n is low:
  - state = IDLE.
  - rsp_valid, rsp_err, rsp_rdata = 0.
  - p0/p1 req_valid = 0; latched address, data, we, be = 0; timer = 0.
- req_ready = (state == IDLE), so it is 1 immediately after reset.
- Reset asserted mid-transaction aborts it: no response is produced, and a late downstream response is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On req_valid && req_ready, latch addr, wdata, we, be.
  - Compute sel = ((req_addr & MMIO_MASK) == MMIO_BASE).
  - If req_be == 4'b0000: go to RESP with rsp_err = 1, rsp_rdata = 0; no downstream request is made.
  - Otherwise go to ISSUE and clear the timer.
- ISSUE:
  - p[sel]_req_valid = 1 with the latched fields; the other port's req_valid = 0 and its fields = 0.
  - Fields stay stable until accepted. On p[sel]_req_ready, go to WAIT.
- WAIT:
  - On p[sel]_rsp_valid, capture rdata (forced to 0 when we = 1), set err = 0, go to RESP.
  - A response from the non-selected port is ignored in every state.
- Timer:
  - Counts every cycle in ISSUE and WAIT. When it reaches TIMEOUT with no completion, go to RESP with rsp_err = 1, rsp_rdata = 0.
  - A completion in the same cycle as the timer reaching TIMEOUT wins: err = 0.
  - The timer saturates and does not wrap.
- RESP: rsp_valid = 1 for exactly one cycle with registered rdata and err, then return to IDLE.
- rsp_rdata holds its last value outside RESP; rsp_err returns to 0.
- Minimum latency, with downstream ready and responding the cycle after accept:
  - accept at cycle N;
  - p*_req_valid at N+1;
  - downstream response at N+2;
  - rsp_valid at N+3.
- No new request is accepted until the cycle after RESP. Back-to-back throughput is one transaction per 4 cycles.

Decomposition:
- Shared package (riscv_bus_pkg):
  - state encoding, 2-bit localparams IDLE=0, ISSUE=1, WAIT=2, RESP=3;
  - default MMIO_BASE and MMIO_MASK;
  - BE_NONE = 4'b0000.
- One sub-module, txn_timer: a saturating counter with clear, enable and a `expired` output, width $clog2(TIMEOUT+1).

Test Plan:
- Load to 32'h0000_0010, be=4'hF, p0 ready immediately, p0 responds 32'hCAFE_F00D one cycle later -> p0_req_valid at N+1, rsp_valid at N+3, rsp_rdata=32'hCAFE_F00D, err=0, p1_req_valid stays 0.
- Store to 32'hFFFF_0004, wdata=32'h0000_00A5, be=4'h1 -> p1_addr=32'hFFFF_0004, p1_we=1, p1_be=4'h1 driven; after the p1 response, rsp_rdata=0, err=0.
- p0_req_ready held low for 5 cycles -> p0 fields stable all 5 cycles, req_ready=0 throughout; completes normally after ready.
- TIMEOUT=8, p0 accepts and never responds -> rsp_valid with err=1, rdata=0 exactly 8 cycles after ISSUE entry; block then accepts the next request.
- be=4'h0 -> no downstream req_valid; rsp_valid at N+1 with err=1.
- rst_n pulsed low during WAIT, then the stale p0_rsp_valid arrives -> no rsp_valid; all outputs 0 during reset, req_ready=1 after release.
